// File: rtl/buscador_binario.sv
// rtl/buscador_binario.sv - binary search over an external magnitude comparator
//
// Purpose: drives operand B (palpite) of an external combinational comparator and
// narrows the interval [lo, hi] with its maior/menor/igual flags until A is found.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   iniciar    in   1      start pulse, honoured only in OCIOSO or FIM
//   maior      in   1      comparator flag: A > palpite
//   menor      in   1      comparator flag: A < palpite
//   igual      in   1      comparator flag: A == palpite
//   palpite    out  WIDTH  current guess (registered)
//   ocupado    out  1      search in progress (PROPOE/AVALIA)
//   pronto     out  1      value found, held until next iniciar
//   erro       out  1      search failed, held until next iniciar
//   resultado  out  WIDTH  found value, valid while pronto=1
//   tentativas out  4      guesses issued, saturating at 15
module buscador_binario #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iniciar,
    input  logic             maior,
    input  logic             menor,
    input  logic             igual,
    output logic [WIDTH-1:0] palpite,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro,
    output logic [WIDTH-1:0] resultado,
    output logic [3:0]       tentativas
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        PROPOE = 2'd1,
        AVALIA = 2'd2,
        FIM    = 2'd3
    } estado_t;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] palpite_q, palpite_d;
    logic [WIDTH-1:0] resultado_q, resultado_d;
    logic [3:0]       tentativas_q, tentativas_d;
    logic             pronto_q, pronto_d;
    logic             erro_q, erro_d;

    // One extra bit so lo+hi never overflows before halving.
    logic [WIDTH:0]   soma;
    logic [WIDTH-1:0] meio;
    logic [WIDTH-1:0] lo_prox;
    logic [WIDTH-1:0] hi_prox;

    assign soma    = {1'b0, lo_q} + {1'b0, hi_q};
    assign meio    = soma[WIDTH:1];
    assign lo_prox = palpite_q + 1'b1;
    assign hi_prox = palpite_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        palpite_d    = palpite_q;
        resultado_d  = resultado_q;
        tentativas_d = tentativas_q;
        pronto_d     = pronto_q;
        erro_d       = erro_q;

        case (state_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    lo_d         = '0;
                    hi_d         = MAX;
                    tentativas_d = 4'd0;
                    pronto_d     = 1'b0;
                    erro_d       = 1'b0;
                    state_d      = PROPOE;
                end
            end
            PROPOE: begin
                palpite_d = meio;
                if (tentativas_q != 4'hF) begin
                    tentativas_d = tentativas_q + 4'd1;
                end
                state_d = AVALIA;
            end
            AVALIA: begin
                case ({maior, menor, igual})
                    3'b001: begin
                        resultado_d = palpite_q;
                        pronto_d    = 1'b1;
                        state_d     = FIM;
                    end
                    3'b100: begin
                        // Guess at MAX would make lo wrap to 0; treat as failure.
                        if (palpite_q == MAX || lo_prox > hi_q) begin
                            erro_d  = 1'b1;
                            state_d = FIM;
                        end else begin
                            lo_d    = lo_prox;
                            state_d = PROPOE;
                        end
                    end
                    3'b010: begin
                        if (palpite_q == '0 || lo_q > hi_prox) begin
                            erro_d  = 1'b1;
                            state_d = FIM;
                        end else begin
                            hi_d    = hi_prox;
                            state_d = PROPOE;
                        end
                    end
                    default: begin
                        // No flag or contradictory flags: comparator is broken.
                        erro_d  = 1'b1;
                        state_d = FIM;
                    end
                endcase
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OCIOSO;
            lo_q         <= '0;
            hi_q         <= MAX;
            palpite_q    <= '0;
            resultado_q  <= '0;
            tentativas_q <= 4'd0;
            pronto_q     <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            palpite_q    <= palpite_d;
            resultado_q  <= resultado_d;
            tentativas_q <= tentativas_d;
            pronto_q     <= pronto_d;
            erro_q       <= erro_d;
        end
    end

    assign palpite    = palpite_q;
    assign resultado  = resultado_q;
    assign tentativas = tentativas_q;
    assign pronto     = pronto_q;
    assign erro       = erro_q;
    assign ocupado    = (state_q == PROPOE) || (state_q == AVALIA);

endmodule

// File: tb/tb_buscador_binario.sv
// tb/tb_buscador_binario.sv - scoreboard bench for buscador_binario
module tb_buscador_binario;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       maior, menor, igual;
    logic [3:0] palpite;
    logic       ocupado, pronto, erro;
    logic [3:0] resultado;
    logic [3:0] tentativas;

    logic [3:0] a_val;
    logic       force_bad;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] res;
        logic [3:0] tent;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] guesses[$];

    // Hand-computed guess counts for A = 0..15 on a 4-bit range.
    int exp_tent[16] = '{4, 3, 4, 2, 4, 3, 4, 1, 4, 3, 4, 2, 4, 3, 4, 5};
    int g15[5]       = '{7, 11, 13, 14, 15};
    int g0[4]        = '{7, 3, 1, 0};

    always #5 clk = ~clk;

    // Reference comparator, with an override that asserts contradictory flags.
    assign maior = force_bad ? 1'b1 : (a_val > palpite);
    assign menor = force_bad ? 1'b1 : (a_val < palpite);
    assign igual = force_bad ? 1'b0 : (a_val == palpite);

    buscador_binario #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .iniciar    (iniciar),
        .maior      (maior),
        .menor      (menor),
        .igual      (igual),
        .palpite    (palpite),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .erro       (erro),
        .resultado  (resultado),
        .tentativas (tentativas)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: every new completion (pronto or erro rising) is matched to the queue.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        logic done_now;
        exp_t e;
        done_now = pronto | erro;
        if (done_now && !done_prev) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_erro", {31'd0, erro}, {31'd0, e.err});
                chk("sb_pronto", {31'd0, pronto}, {31'd0, ~e.err});
                chk("sb_tentativas", {28'd0, tentativas}, {28'd0, e.tent});
                if (!e.err) chk("sb_resultado", {28'd0, resultado}, {28'd0, e.res});
            end
        end
        done_prev = done_now;
    end

    task automatic run_search(input logic [3:0] a, input int t_exp, input logic err_exp,
                              input bit mid_pulse);
        int  cnt;
        bit  fin;
        a_val = a;
        sb_q.push_back('{a, t_exp[3:0], err_exp});
        guesses.delete();
        @(negedge clk);
        iniciar = 1'b1;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
        chk("start_state", {28'd0, ocupado, pronto, erro, 1'b0} | {28'd0, tentativas}, {28'd0, 4'b1000});
        cnt = 0;
        fin = 1'b0;
        while (!fin && cnt < 40) begin
            if (mid_pulse && cnt == 3) iniciar = 1'b1;
            @(posedge clk);
            #1;
            cnt++;
            if (mid_pulse && cnt == 4) begin
                iniciar = 1'b0;
                chk("iniciar_ignored_tentativas", {28'd0, tentativas}, 32'd2);
            end
            if ((cnt % 2) == 1 && ocupado) guesses.push_back(palpite);
            fin = pronto | erro;
        end
        chk("latency_edges", cnt, 2 * t_exp);
    endtask

    initial begin
        reset     = 1'b1;
        iniciar   = 1'b0;
        a_val     = 4'd0;
        force_bad = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, palpite, resultado, tentativas},  32'd0);
        chk("reset_flags", {29'd0, ocupado, pronto, erro}, 32'd0);
        reset = 1'b0;

        run_search(4'd7, 1, 1'b0, 1'b0);
        chk("a7_guess", {28'd0, guesses[0]}, 32'd7);

        run_search(4'd15, 5, 1'b0, 1'b1);
        chk("a15_nguess", guesses.size(), 32'd5);
        for (int i = 0; i < 5 && i < guesses.size(); i++)
            chk("a15_guess", {28'd0, guesses[i]}, g15[i]);

        run_search(4'd0, 4, 1'b0, 1'b0);
        chk("a0_nguess", guesses.size(), 32'd4);
        for (int i = 0; i < 4 && i < guesses.size(); i++)
            chk("a0_guess", {28'd0, guesses[i]}, g0[i]);

        for (int a = 0; a < 16; a++)
            run_search(a[3:0], exp_tent[a], 1'b0, 1'b0);

        force_bad = 1'b1;
        run_search(4'd9, 1, 1'b1, 1'b0);
        force_bad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("erro_held_in_fim", {30'd0, erro, pronto}, 32'd2);
        // run_search's start check covers erro being cleared by iniciar.
        run_search(4'd9, 3, 1'b0, 1'b0);

        // Abort an A=15 search while in AVALIA.
        a_val = 4'd15;
        @(negedge clk);
        iniciar = 1'b1;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_ocupado", {31'd0, ocupado}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_values", {20'd0, palpite, resultado, tentativas}, 32'd0);
        chk("abort_flags", {29'd0, ocupado, pronto, erro}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_abort", {31'd0, ocupado}, 32'd0);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
